// File: rtl/turbo_pkg.sv
// Shared types and constants for the LTE turbo encoder path: FSM states,
// constituent code polynomials and block-length limits.
package turbo_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      TAIL = 2'd2
   } enc_state_e;

   // Polynomial bit i is the coefficient of D^i.
   localparam logic [3:0] G0 = 4'b1101;
   localparam logic [3:0] G1 = 4'b1011;

   localparam int LLR_W      = 16;
   localparam int LLR_MAG    = 1024;
   localparam int BLKLEN_MIN = 40;
   localparam int BLKLEN_MAX = 6144;

   localparam int CNT_W      = 13;
   localparam int TAIL_STEPS = 3;

endpackage

// File: rtl/rsc_trellis_step.sv
// One combinational step of the rate-1/2 RSC trellis. The state vector holds
// s = {s1, s2, s3}; s1 is the most recent feedback value.
module rsc_trellis_step
   import turbo_pkg::*;
(
   input  logic [2:0] s,
   input  logic       u,
   input  logic       tail,
   output logic       sys_bit,
   output logic       parity_bit,
   output logic [2:0] s_next
);

   logic fb;
   logic u_eff;
   logic a;

   // During termination the input is forced to the feedback so the register
   // fills with zeros after three steps.
   always_comb begin
      fb         = ^(s & {G0[1], G0[2], G0[3]});
      u_eff      = tail ? fb : u;
      a          = u_eff ^ fb;
      sys_bit    = u_eff;
      parity_bit = (G1[0] & a) ^ (^(s & {G1[1], G1[2], G1[3]}));
      s_next     = {a, s[2], s[1]};
   end

endmodule

// File: rtl/rsc_encoder.sv
// LTE turbo constituent encoder: encodes K info bits, appends three
// termination steps, and emits registered hard bits plus BPSK soft samples.
module rsc_encoder #(
   parameter int BLKLEN_MIN = turbo_pkg::BLKLEN_MIN,
   parameter int BLKLEN_MAX = turbo_pkg::BLKLEN_MAX,
   parameter int LLR_W      = turbo_pkg::LLR_W,
   parameter int LLR_MAG    = turbo_pkg::LLR_MAG
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [15:0]             blklen,
   input  logic                    valid_blklen,
   input  logic                    bit_in,
   input  logic                    valid_in,
   output logic                    ready_in,
   output logic                    sys_bit,
   output logic                    parity_bit,
   output logic signed [LLR_W-1:0] sys,
   output logic signed [LLR_W-1:0] parity,
   output logic                    valid_out,
   input  logic                    ready_out,
   output logic                    tail_out,
   output logic                    last_out,
   output logic                    err_blklen
);

   localparam int CNT_W = turbo_pkg::CNT_W;
   localparam logic [CNT_W-1:0] TAIL_LAST = CNT_W'(turbo_pkg::TAIL_STEPS - 1);
   localparam logic [LLR_W-1:0] LLR_POS = LLR_W'(LLR_MAG);
   localparam logic [LLR_W-1:0] LLR_NEG = LLR_W'(-LLR_MAG);

   turbo_pkg::enc_state_e state;
   turbo_pkg::enc_state_e state_next;

   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] k_last;
   logic [2:0]       s;
   logic [2:0]       s_next;
   logic             adv;
   logic             blk_legal;
   logic             blk_start;
   logic             in_xfer;
   logic             step_tail;
   logic             step_issue;
   logic             step_final;
   logic             step_sys;
   logic             step_par;

   assign adv       = !valid_out || ready_out;
   assign blk_legal = (blklen >= 16'(BLKLEN_MIN)) && (blklen <= 16'(BLKLEN_MAX));
   assign blk_start = (state == turbo_pkg::IDLE) && valid_blklen && blk_legal;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= turbo_pkg::IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         turbo_pkg::IDLE: if (blk_start)                    state_next = turbo_pkg::DATA;
         turbo_pkg::DATA: if (in_xfer && count == k_last)   state_next = turbo_pkg::TAIL;
         turbo_pkg::TAIL: if (adv && count == TAIL_LAST)    state_next = turbo_pkg::IDLE;
         default:                                           state_next = turbo_pkg::IDLE;
      endcase
   end

   // A step is issued only when the output register is free, either from an
   // accepted input bit or self-issued during termination.
   always_comb begin
      ready_in   = (state == turbo_pkg::DATA) && adv;
      in_xfer    = ready_in && valid_in;
      step_tail  = (state == turbo_pkg::TAIL);
      step_issue = in_xfer || (step_tail && adv);
      step_final = step_tail ? (count == TAIL_LAST) : (count == k_last);
   end

   rsc_trellis_step u_step (
      .s          (s),
      .u          (bit_in),
      .tail       (step_tail),
      .sys_bit    (step_sys),
      .parity_bit (step_par),
      .s_next     (s_next)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s          <= '0;
         count      <= '0;
         k_last     <= '0;
         sys_bit    <= 1'b0;
         parity_bit <= 1'b0;
         sys        <= '0;
         parity     <= '0;
         valid_out  <= 1'b0;
         tail_out   <= 1'b0;
         last_out   <= 1'b0;
         err_blklen <= 1'b0;
      end else begin
         err_blklen <= (state == turbo_pkg::IDLE) && valid_blklen && !blk_legal;
         if (blk_start) begin
            k_last <= CNT_W'(blklen - 16'd1);
            count  <= '0;
         end
         if (step_issue) begin
            s          <= s_next;
            sys_bit    <= step_sys;
            parity_bit <= step_par;
            sys        <= step_sys ? LLR_NEG : LLR_POS;
            parity     <= step_par ? LLR_NEG : LLR_POS;
            valid_out  <= 1'b1;
            tail_out   <= step_tail;
            last_out   <= step_tail && step_final;
            count      <= step_final ? '0 : count + 1'b1;
         end else if (adv) begin
            valid_out <= 1'b0;
            tail_out  <= 1'b0;
            last_out  <= 1'b0;
         end
      end
   end

   // Three forced-zero feedback steps must always flush the register.
   assert property (@(posedge clk) disable iff (!rst)
      (step_issue && step_tail && count == TAIL_LAST) |=> (s == 3'b000));

endmodule

// File: tb/tb_rsc_encoder.sv
// Scoreboard bench for rsc_encoder: a polynomial-division reference model
// predicts every output step; a negedge monitor compares as steps transfer.
module tb_rsc_encoder;

   localparam int LLR_MAG = 1024;

   logic               clk = 1'b0;
   logic               rst;
   logic [15:0]        blklen;
   logic               valid_blklen;
   logic               bit_in;
   logic               valid_in;
   logic               ready_in;
   logic               sys_bit;
   logic               parity_bit;
   logic signed [15:0] sys;
   logic signed [15:0] parity;
   logic               valid_out;
   logic               ready_out;
   logic               tail_out;
   logic               last_out;
   logic               err_blklen;

   typedef struct {
      bit sys_b;
      bit par_b;
      bit tail;
      bit last;
   } step_t;

   step_t       exp_q[$];
   bit          par_log[$];
   step_t       e;
   int          n_checks = 0;
   int          n_pass   = 0;
   int          n_steps  = 0;
   bit          stall_en = 1'b0;
   bit          held     = 1'b0;
   logic [35:0] snap;

   rsc_encoder dut (
      .clk          (clk),
      .rst          (rst),
      .blklen       (blklen),
      .valid_blklen (valid_blklen),
      .bit_in       (bit_in),
      .valid_in     (valid_in),
      .ready_in     (ready_in),
      .sys_bit      (sys_bit),
      .parity_bit   (parity_bit),
      .sys          (sys),
      .parity       (parity),
      .valid_out    (valid_out),
      .ready_out    (ready_out),
      .tail_out     (tail_out),
      .last_out     (last_out),
      .err_blklen   (err_blklen)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
   endtask

   task automatic finishSim();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   endtask

   function automatic logic [15:0] llr(input bit b);
      return b ? 16'(-LLR_MAG) : 16'(LLR_MAG);
   endfunction

   // Reference: feedback sequence a_k = u_k ^ a_{k-2} ^ a_{k-3},
   // parity z_k = a_k ^ a_{k-1} ^ a_{k-3}; termination drives a_k to 0.
   task automatic pushExpected(input int k, input bit bits[$]);
      bit a[$];
      a.push_back(1'b0); a.push_back(1'b0); a.push_back(1'b0);
      for (int i = 0; i < k + 3; i++) begin
         int    n;
         bit    tail, u, fb, an;
         step_t st;
         n    = a.size();
         tail = (i >= k);
         u    = 1'b0;
         if (!tail) u = bits[i];
         fb   = a[n-2] ^ a[n-3];
         an   = tail ? 1'b0 : (u ^ fb);
         st.sys_b = tail ? fb : u;
         st.par_b = an ^ a[n-1] ^ a[n-3];
         st.tail  = tail;
         st.last  = (i == k + 2);
         exp_q.push_back(st);
         a.push_back(an);
      end
   endtask

   always @(negedge clk) begin
      if (rst === 1'b1 && valid_out === 1'b1) begin
         if (held)
            checkOutput("stall_hold", {sys_bit, parity_bit, tail_out, last_out, sys, parity}, snap);
         if (ready_out) begin
            held = 1'b0;
            if (exp_q.size() == 0) begin
               checkOutput("unexpected_step", 1, 0);
            end else begin
               e = exp_q.pop_front();
               checkOutput($sformatf("step%0d", n_steps),
                           {sys_bit, parity_bit, tail_out, last_out, sys, parity},
                           {e.sys_b, e.par_b, e.tail, e.last, llr(e.sys_b), llr(e.par_b)});
               par_log.push_back(parity_bit);
               n_steps++;
            end
         end else begin
            held = 1'b1;
            snap = {sys_bit, parity_bit, tail_out, last_out, sys, parity};
         end
      end
   end

   initial begin
      ready_out = 1'b1;
      forever begin
         @(posedge clk); #1;
         ready_out = stall_en ? ($urandom_range(3) != 0) : 1'b1;
      end
   end

   // pattern 0 random, 1 all zeros, 2 single leading one
   task automatic applyStimulus(input int k, input int n_send, input int pattern, input bit gaps);
      bit bits[$];
      int budget;
      for (int i = 0; i < k; i++)
         bits.push_back(pattern == 0 ? 1'($urandom) : (pattern == 2 && i == 0));
      pushExpected(k, bits);
      blklen       = 16'(k);
      valid_blklen = 1'b1;
      for (int i = 0; i < n_send; i++) begin
         if (gaps && $urandom_range(3) == 0) begin
            valid_in = 1'b0;
            @(posedge clk); #1;
         end
         bit_in   = bits[i];
         valid_in = 1'b1;
         budget   = 0;
         do begin
            @(negedge clk);
            budget++;
         end while (!ready_in && budget < 200);
         if (!ready_in) begin
            checkOutput("input_timeout", 0, 1);
            finishSim();
         end
         @(posedge clk); #1;
         valid_blklen = 1'b0;
      end
      valid_in = 1'b0;
   endtask

   task automatic drainCheck(input string name, input int base, input int steps);
      int budget = 0;
      while ((exp_q.size() != 0 || valid_out) && budget < 20000) begin
         @(posedge clk); #2;
         budget++;
      end
      checkOutput({name, "_drained"}, exp_q.size(), 0);
      checkOutput({name, "_steps"}, n_steps - base, steps);
      if (budget >= 20000) finishSim();
   endtask

   task automatic badBlklen(input int k);
      @(posedge clk); #1;
      blklen       = 16'(k);
      valid_blklen = 1'b1;
      @(posedge clk); #1;
      valid_blklen = 1'b0;
      @(negedge clk);
      checkOutput($sformatf("err_pulse_%0d", k), err_blklen, 1);
      checkOutput($sformatf("err_ready_%0d", k), ready_in, 0);
      @(negedge clk);
      checkOutput($sformatf("err_clear_%0d", k), {err_blklen, ready_in, valid_out}, 0);
   endtask

   initial begin
      bit exp_par[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      int base;
      rst = 1'b0; blklen = '0; valid_blklen = 1'b0; bit_in = 1'b0; valid_in = 1'b0;
      #12;
      checkOutput("reset_outputs",
                  {valid_out, ready_in, sys_bit, parity_bit, tail_out, last_out, err_blklen, sys, parity}, 0);
      @(posedge clk); #3;
      rst = 1'b1;

      $display("[TB] all-zero block K=40");
      base = n_steps;
      applyStimulus(40, 40, 1, 1'b0);
      drainCheck("zero_blk", base, 43);

      $display("[TB] impulse block K=40");
      base = n_steps;
      par_log.delete();
      applyStimulus(40, 40, 2, 1'b0);
      drainCheck("impulse_blk", base, 43);
      for (int j = 0; j < 5; j++)
         checkOutput($sformatf("impulse_parity%0d", j), par_log[j], exp_par[j]);

      $display("[TB] illegal block lengths");
      badBlklen(39);
      badBlklen(6145);

      $display("[TB] back-to-back blocks K=40");
      base = n_steps;
      applyStimulus(40, 40, 0, 1'b1);
      applyStimulus(40, 40, 0, 1'b1);
      drainCheck("b2b_blk", base, 86);

      $display("[TB] random block K=6144 with stalls");
      stall_en = 1'b1;
      base = n_steps;
      applyStimulus(6144, 6144, 0, 1'b1);
      drainCheck("max_blk", base, 6147);
      stall_en = 1'b0;

      $display("[TB] reset mid-block");
      applyStimulus(40, 20, 0, 1'b0);
      @(posedge clk); @(posedge clk); #3;
      rst = 1'b0;
      #1;
      checkOutput("reset_mid_outputs",
                  {valid_out, ready_in, sys_bit, parity_bit, tail_out, last_out, sys, parity}, 0);
      exp_q.delete();
      held = 1'b0;
      @(posedge clk); @(posedge clk); #3;
      rst = 1'b1;
      @(negedge clk);
      checkOutput("post_reset_idle", {ready_in, valid_out}, 0);
      base = n_steps;
      applyStimulus(40, 40, 0, 1'b1);
      drainCheck("post_reset_blk", base, 43);

      finishSim();
   end

   initial begin
      #3000000;
      checkOutput("watchdog", 0, 1);
      finishSim();
   end

endmodule
